// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the LC-3 sequencer: state enum, opcodes, mux encodings and
// the Moore output decode. Optional macro FETCH_PAUSE_EN adds the fetch-pause states.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        Halted,
        S_18,
        S_33,
        S_35,
        S_32,
        S_01,
        S_05,
        S_09,
        S_00,
        S_22,
        S_12,
        S_04,
        S_21,
        S_20,
        S_06,
        S_07,
        S_25,
        S_27,
        S_23,
        S_16,
        PauseIR1,
        PauseIR2
`ifdef FETCH_PAUSE_EN
        ,
        FetchPause1,
        FetchPause2
`endif
    } state_e;

    // IR[15:12] values
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    // PCMUX: 01 selects the bus, which no state here uses
    localparam logic [1:0] PCMUX_PC1  = 2'b00;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // States that hold the SRAM strobe for a counted number of cycles
    function automatic logic is_mem_wait(input state_e st);
        return (st == S_33) || (st == S_25) || (st == S_16);
    endfunction

    // Control word for a state; last marks the final cycle of a memory wait
    function automatic ctrl_t decode_ctrl(input state_e st, input logic ir_5, input logic last);
        ctrl_t c;
        c = '0;
        case (st)
            S_18: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.ld_pc   = 1'b1;
                c.pcmux   = PCMUX_PC1;
            end
            S_33, S_25: begin
                c.mem_oe = 1'b1;
                c.ld_mdr = last;
            end
            S_35: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            S_32: c.ld_ben = 1'b1;
            S_01, S_05: begin
                c.sr1mux   = 1'b1;
                c.sr2mux   = ir_5;
                c.aluk     = (st == S_01) ? ALUK_ADD : ALUK_AND;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_09: begin
                c.sr1mux   = 1'b1;
                c.aluk     = ALUK_NOT;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_22: begin
                c.addr1mux = 1'b0;
                c.addr2mux = ADDR2_OFF9;
                c.pcmux    = PCMUX_ADDR;
                c.ld_pc    = 1'b1;
            end
            S_12, S_20: begin
                c.sr1mux   = 1'b1;
                c.addr1mux = 1'b1;
                c.addr2mux = ADDR2_ZERO;
                c.pcmux    = PCMUX_ADDR;
                c.ld_pc    = 1'b1;
            end
            S_04: begin
                c.gate_pc = 1'b1;
                c.drmux   = 1'b1;
                c.ld_reg  = 1'b1;
            end
            S_21: begin
                c.addr1mux = 1'b0;
                c.addr2mux = ADDR2_OFF11;
                c.pcmux    = PCMUX_ADDR;
                c.ld_pc    = 1'b1;
            end
            S_06, S_07: begin
                c.sr1mux      = 1'b1;
                c.addr1mux    = 1'b1;
                c.addr2mux    = ADDR2_OFF6;
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
            end
            S_27: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_23: begin
                c.sr1mux   = 1'b0;
                c.aluk     = ALUK_PASSA;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
            end
            S_16:     c.mem_we = 1'b1;
            PauseIR1: c.ld_led = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// SRAM access wait counter shared by the fetch read, LDR read and STR write states.
// Counts 0..MEM_WAIT-1 while active; done flags the final cycle of the current
// access, last flags that the next cycle's count will be the final one.
module mem_wait_ctr #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = $clog2(MEM_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    output logic last,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_WAIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = active && (cnt_q == LAST_CNT);

    // Restart on entry, advance during a wait, clear once the access completes
    always_comb begin
        cnt_d = '0;
        if (start) begin
            cnt_d = '0;
        end else if (active && !done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign last = (cnt_d == LAST_CNT);

    // Counter register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_seq_ctrl.sv
// LC-3 instruction sequencer for the SLC-3 datapath. Outputs are a registered Moore
// decode of the state, so they change on the same edge as the state does.
// Optional macro FETCH_PAUSE_EN inserts a two-step pause after each fetch.
module lc3_seq_ctrl #(
    parameter int MEM_WAIT = 2,  // legal 1..8
    parameter int CNT_W    = $clog2(MEM_WAIT + 1)  // derived, do not override
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);
    import lc3_ctrl_pkg::*;

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   wait_start, wait_active, wait_last, wait_done;

    assign wait_active = is_mem_wait(state_q);
    assign wait_start  = is_mem_wait(state_d) && !wait_active;

    mem_wait_ctr #(
        .MEM_WAIT(MEM_WAIT),
        .CNT_W   (CNT_W)
    ) u_wait (
        .clk   (Clk),
        .rst_n (Reset_n),
        .start (wait_start),
        .active(wait_active),
        .last  (wait_last),
        .done  (wait_done)
    );

    // Next-state rules of the fetch/decode/execute flow
    always_comb begin
        state_d = state_q;
        case (state_q)
            Halted: if (Run) state_d = S_18;
            S_18:   state_d = S_33;
            S_33:   if (wait_done) state_d = S_35;
`ifdef FETCH_PAUSE_EN
            S_35:        state_d = FetchPause1;
            FetchPause1: if (Continue) state_d = FetchPause2;
            FetchPause2: if (!Continue) state_d = S_32;
`else
            S_35:   state_d = S_32;
`endif
            S_32: begin
                case (Opcode)
                    OP_ADD:  state_d = S_01;
                    OP_AND:  state_d = S_05;
                    OP_NOT:  state_d = S_09;
                    OP_BR:   state_d = S_00;
                    OP_JMP:  state_d = S_12;
                    OP_JSR:  state_d = S_04;
                    OP_LDR:  state_d = S_06;
                    OP_STR:  state_d = S_07;
                    OP_PSE:  state_d = PauseIR1;
                    default: state_d = S_18;
                endcase
            end
            S_01, S_05, S_09:       state_d = S_18;
            S_00:                   state_d = BEN ? S_22 : S_18;
            S_22, S_12, S_21, S_20: state_d = S_18;
            S_04:                   state_d = IR_11 ? S_21 : S_20;
            S_06:                   state_d = S_25;
            S_07:                   state_d = S_23;
            S_25:                   if (wait_done) state_d = S_27;
            S_27:                   state_d = S_18;
            S_23:                   state_d = S_16;
            S_16:                   if (wait_done) state_d = S_18;
            // Two-step handshake so a held Continue releases exactly once
            PauseIR1:               if (Continue) state_d = PauseIR2;
            PauseIR2:               if (!Continue) state_d = S_18;
            default:                state_d = Halted;
        endcase
    end

    // State and registered control word, both cleared asynchronously
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= Halted;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d, IR_5, wait_last);
        end
    end

    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign PCMUX      = ctrl_q.pcmux;
    assign DRMUX      = ctrl_q.drmux;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign SR2MUX     = ctrl_q.sr2mux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign ALUK       = ctrl_q.aluk;
    assign Mem_OE     = ctrl_q.mem_oe;
    assign Mem_WE     = ctrl_q.mem_we;

endmodule

// File: doc/lc3_seq_ctrl.md
Name: lc3_seq_ctrl

Overview:
- Complete LC-3 instruction sequencer (ISDU successor) for the ECE 385 SLC-3 datapath.
- Drives the datapath load/gate/mux controls and the SRAM strobes.
- Memory access length is parametrised by a wait-cycle counter instead of hard-coded states.
- Implements the full fetch/decode/execute flow: ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR, PAUSE.

Parameters:
- MEM_WAIT, 2: cycles Mem_OE/Mem_WE is held per SRAM access; legal 1..8.
- CNT_W, $clog2(MEM_WAIT+1): wait counter width (derived, not overridden).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  leave Halted.
- Continue  in  1  PAUSE release, level.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  imm5 select.
- IR_11  in  1  JSR/JSRR select.
- BEN  in  1  registered branch-enable.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
- PCMUX  out  2  00=PC+1, 01=bus, 10=address adder.
- DRMUX  out  1  0=IR[11:9], 1=R7.
- SR1MUX  out  1  0=IR[11:9], 1=IR[8:6].
- SR2MUX  out  1  0=SR2, 1=imm5.
- ADDR1MUX  out  1  0=PC, 1=SR1.
- ADDR2MUX  out  2  00=0, 01=off6, 10=off9, 11=off11.
- ALUK  out  2  00=ADD, 01=AND, 10=NOT, 11=PASSA.
- Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-high.

Behaviour:
- Reset_n low: state=Halted, wait counter=0, all outputs 0, asynchronously. Reset mid-access aborts the access immediately.
- Outputs are a Moore decode of state. Every signal defaults to 0 unless listed for the state.
- Halted: Run=1 -> S_18.
- S_18: GatePC, LD_MAR, LD_PC, PCMUX=00 -> S_33.
- S_33: Mem_OE for MEM_WAIT cycles, counter 0..MEM_WAIT-1; LD_MDR on the cycle the counter reads MEM_WAIT-1; then -> S_35 with counter cleared.
- S_35: GateMDR, LD_IR -> S_32.
- S_32: LD_BEN; decode Opcode: 0001->S_01, 0101->S_05, 1001->S_09, 0000->S_00, 1100->S_12, 0100->S_04, 0110->S_06, 0111->S_07, 1101->PauseIR1, others->S_18 (NOP).
- S_01/S_05: SR1MUX=1, SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC -> S_18.
- S_09: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC -> S_18.
- S_00: BEN ? S_22 : S_18. BEN is the value loaded in S_32.
- S_22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S_18.
- S_12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S_18.
- S_04: GatePC, DRMUX=1, LD_REG -> IR_11 ? S_21 : S_20.
- S_21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC -> S_18.
- S_20: as S_12 -> S_18. JSRR with BaseR=R7 jumps to the new R7; this is a documented limitation.
- S_06/S_07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> S_25/S_23.
- S_25: read wait, identical to S_33 -> S_27.
- S_27: GateMDR, LD_REG, LD_CC -> S_18.
- S_23: SR1MUX=0, ALUK=11, GateALU, LD_MDR -> S_16.
- S_16: Mem_WE for MEM_WAIT cycles (counted) -> S_18.
- PauseIR1: LD_LED every cycle; Continue=1 -> PauseIR2.
- PauseIR2: Continue=0 -> S_18. A held Continue never double-steps.
- Run is ignored outside Halted.
- MEM_WAIT=1: single-cycle access, LD_MDR asserted in that same cycle.

Optional Feature:
- FETCH_PAUSE_EN defined:
  - S_35 -> FetchPause1 (wait Continue=1) -> FetchPause2 (wait Continue=0) -> S_32.
  - Fetch-pause states assert nothing, so IR is visible for single-step demo.
- FETCH_PAUSE_EN undefined: S_35 -> S_32 directly; fetch-pause states are not compiled.

Decomposition:
- Package lc3_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_ADD etc.);
  - PCMUX, ADDR2MUX and ALUK encodings.
- Sub-module mem_wait_ctr (inputs: start/active; outputs: last, done): shared by S_33, S_25 and S_16.

Test Plan:
- Reset_n low during S_33 with MEM_WAIT=2 -> all outputs 0 within the same cycle; state Halted; Run=1 afterwards -> S_18 next edge.
- Fetch, MEM_WAIT=3 -> Mem_OE high exactly 3 cycles; LD_MDR only in the 3rd; LD_IR one cycle later.
- Opcode=0001, IR_5=1 -> S_01 asserts SR2MUX=1, ALUK=00, GateALU, LD_REG, LD_CC; then S_18.
- Opcode=0000, BEN=0 -> S_00 then S_18, no LD_PC. BEN=1 -> S_22 with PCMUX=10, ADDR2MUX=10, LD_PC.
- Opcode=0111, MEM_WAIT=2 -> S_07 (LD_MAR), S_23 (ALUK=11, LD_MDR), Mem_WE 2 cycles, S_18.
- Opcode=1101 -> LD_LED high while Continue=0; Continue 1 for 50 cycles -> stays PauseIR2; Continue 0 -> S_18 once.
